// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter in front of the single-port data memory: one ARB cycle, then one ACCESS cycle.
// Optional statistics counters are enabled by defining MEM_ARB_STATS_EN.
module data_mem_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic                        mem_wen,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]       grant_cnt,
  output logic [15:0]                 stall_cnt
`endif
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [0:0] ST_ARB    = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  logic [0:0]          state_q;
  logic [IdxW-1:0]     rr_last_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [NUM_REQ-1:0]  rvalid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                cmd_we_q;
  logic [ADDR_W-1:0]   cmd_addr_q;
  logic [DATA_W-1:0]   cmd_wdata_q;

  logic [IdxW-1:0]     win_idx;
  logic [NUM_REQ-1:0]  win_onehot;
  logic                win_found;
  logic                arb_fire;

  // Scan starting just after the last winner so every requester gets a turn.
  always_comb begin
    int unsigned cand;
    logic [IdxW-1:0] cand_idx;
    cand       = 0;
    cand_idx   = '0;
    win_idx    = rr_last_q;
    win_found  = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand     = (32'(rr_last_q) + i) % NUM_REQ;
      cand_idx = IdxW'(cand);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
  end

  assign arb_fire = (state_q == ST_ARB) && win_found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ARB;
      rr_last_q   <= IdxW'(NUM_REQ - 1);
      gnt_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
    end else begin
      case (state_q)
        ST_ARB: begin
          rvalid_q <= '0;
          if (win_found) begin
            cmd_we_q    <= req_we[win_idx];
            cmd_addr_q  <= req_addr[win_idx*ADDR_W +: ADDR_W];
            cmd_wdata_q <= req_wdata[win_idx*DATA_W +: DATA_W];
            gnt_q       <= win_onehot;
            rr_last_q   <= win_idx;
            state_q     <= ST_ACCESS;
          end else begin
            gnt_q <= '0;
          end
        end
        default: begin
          gnt_q <= '0;
          if (!cmd_we_q) begin
            rdata_q  <= mem_rdata;
            rvalid_q <= gnt_q;
          end else begin
            rvalid_q <= '0;
          end
          state_q <= ST_ARB;
        end
      endcase
    end
  end

  // Write enable depends only on registered state so requester glitches never reach memory.
  assign mem_wen   = (state_q == ST_ACCESS) & cmd_we_q;
  assign mem_addr  = cmd_addr_q;
  assign mem_wdata = cmd_wdata_q;
  assign gnt       = gnt_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] grant_cnt_q [NUM_REQ];
  logic [15:0] stall_cnt_q;
  logic        contended;

  // More than one request bit set means somebody loses this arbitration.
  assign contended = (state_q == ST_ARB) && (|(req & (req - NUM_REQ'(1))));

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_grant_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        grant_cnt_q[g] <= '0;
      end else if (arb_fire && win_onehot[g] && (grant_cnt_q[g] != 16'hFFFF)) begin
        grant_cnt_q[g] <= grant_cnt_q[g] + 16'd1;
      end
    end
    assign grant_cnt[g*16 +: 16] = grant_cnt_q[g];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (contended && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: vector table, directed corner sequences and a randomized run
// against a transaction-level round-robin model with its own memory image.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [7:0]  rdata;
  logic        mem_wen;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] grant_cnt;
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // The shared memory the arbiter sits in front of.
  logic [7:0] mem [256] = '{default: 8'h00};
  always @(posedge clk) if (mem_wen) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  data_mem_arbiter #(
    .NUM_REQ (2),
    .ADDR_W  (8),
    .DATA_W  (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef MEM_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] req;
    logic [1:0] we;
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] gnt;
    logic [1:0] rv;
    logic       wen;
    logic [7:0] rd;
    logic       chk_rd;
  } vec_t;

  vec_t tbl [12];

  // Reference model state for the random run.
  logic [7:0] refmem [256];
  logic       m_acc;
  logic       m_last;
  logic       m_win;
  logic       m_we;
  logic [7:0] m_addr;
  logic [7:0] m_wd;
  logic [1:0] e_gnt;
  logic [1:0] e_rv;
  logic [7:0] e_rd;

  task automatic new_req(input logic i);
    req[i]    = 1'b1;
    req_we[i] = 1'($urandom_range(0, 1));
    if (i) begin
      req_addr[15:8]  = 8'($urandom_range(0, 15));
      req_wdata[15:8] = 8'($urandom);
    end else begin
      req_addr[7:0]  = 8'($urandom_range(0, 15));
      req_wdata[7:0] = 8'($urandom);
    end
  endtask

  initial begin
    //   req    we     a0     a1     d0     d1     gnt    rv     wen   rd     chk_rd
    tbl[0]  = '{2'b01, 2'b01, 8'h10, 8'h00, 8'hA5, 8'h00, 2'b01, 2'b00, 1'b1, 8'h00, 1'b0};
    tbl[1]  = '{2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0};
    tbl[2]  = '{2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 2'b01, 2'b00, 1'b0, 8'h00, 1'b0};
    tbl[3]  = '{2'b00, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 2'b00, 2'b01, 1'b0, 8'hA5, 1'b1};
    tbl[4]  = '{2'b00, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 8'hA5, 1'b1};
    tbl[5]  = '{2'b11, 2'b10, 8'hFF, 8'hFF, 8'h00, 8'h3C, 2'b10, 2'b00, 1'b1, 8'h00, 1'b0};
    tbl[6]  = '{2'b11, 2'b10, 8'hFF, 8'hFF, 8'h00, 8'h3C, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0};
    tbl[7]  = '{2'b11, 2'b00, 8'hFF, 8'hFF, 8'h00, 8'h00, 2'b01, 2'b00, 1'b0, 8'h00, 1'b0};
    tbl[8]  = '{2'b11, 2'b00, 8'hFF, 8'hFF, 8'h00, 8'h00, 2'b00, 2'b01, 1'b0, 8'h3C, 1'b1};
    tbl[9]  = '{2'b11, 2'b00, 8'hFF, 8'hFF, 8'h00, 8'h00, 2'b10, 2'b00, 1'b0, 8'h3C, 1'b1};
    tbl[10] = '{2'b11, 2'b00, 8'hFF, 8'hFF, 8'h00, 8'h00, 2'b00, 2'b10, 1'b0, 8'h3C, 1'b1};
    tbl[11] = '{2'b00, 2'b00, 8'hFF, 8'hFF, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 8'h3C, 1'b1};

    // Reset held with both requesters active: nothing may be granted.
    rst_n     = 1'b0;
    req       = 2'b11;
    req_we    = 2'b11;
    req_addr  = 16'h0102;
    req_wdata = 16'h5566;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_rvalid", 32'(rvalid), 32'h0);
      chk("rst_wen", 32'(mem_wen), 32'h0);
      chk("rst_rdata", 32'(rdata), 32'h0);
    end
    req   = 2'b00;
    rst_n = 1'b1;

    // Write/read on requester 0, then contention with rotation.
    for (int r = 0; r < 12; r++) begin
      req       = tbl[r].req;
      req_we    = tbl[r].we;
      req_addr  = {tbl[r].a1, tbl[r].a0};
      req_wdata = {tbl[r].d1, tbl[r].d0};
      tick();
      chk($sformatf("tbl%0d_gnt", r), 32'(gnt), 32'(tbl[r].gnt));
      chk($sformatf("tbl%0d_rvalid", r), 32'(rvalid), 32'(tbl[r].rv));
      chk($sformatf("tbl%0d_wen", r), 32'(mem_wen), 32'(tbl[r].wen));
      if (tbl[r].chk_rd) chk($sformatf("tbl%0d_rdata", r), 32'(rdata), 32'(tbl[r].rd));
    end
`ifdef MEM_ARB_STATS_EN
    chk("stats_grant0", 32'(grant_cnt[15:0]), 32'd3);
    chk("stats_grant1", 32'(grant_cnt[31:16]), 32'd2);
    chk("stats_stall", 32'(stall_cnt), 32'd3);
`endif

    // Address change after the latch edge must not redirect the write.
    req = 2'b01; req_we = 2'b01; req_addr = 16'h0020; req_wdata = 16'h0011;
    tick();
    chk("late_gnt", 32'(gnt), 32'h1);
    chk("late_wen", 32'(mem_wen), 32'h1);
    chk("late_addr", 32'(mem_addr), 32'h20);
    req_addr = 16'h0021;
    tick();
    req = 2'b00;
    tick();
    chk("late_mem20", 32'(mem[8'h20]), 32'h11);
    chk("late_mem21", 32'(mem[8'h21]), 32'h00);

    // Reset during a write ACCESS: write is dropped, arbitration restarts at requester 0.
    req = 2'b01; req_we = 2'b01; req_addr = 16'h0005; req_wdata = 16'h0077;
    tick();
    chk("rma_gnt", 32'(gnt), 32'h1);
    chk("rma_wen", 32'(mem_wen), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rma_wen_drop", 32'(mem_wen), 32'h0);
    chk("rma_gnt_clr", 32'(gnt), 32'h0);
    req = 2'b00;
    tick();
    rst_n = 1'b1;
    req = 2'b11; req_we = 2'b00; req_addr = 16'h0505;
    tick();
    chk("rma_fresh_gnt", 32'(gnt), 32'h1);
    tick();
    req = 2'b00;
    chk("rma_rvalid", 32'(rvalid), 32'h1);
    chk("rma_rdata", 32'(rdata), 32'h00);
    tick();

    // Randomized run against the transaction-level model.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int a = 0; a < 256; a++) refmem[a] = mem[a];
    m_acc = 1'b0; m_last = 1'b1; m_win = 1'b0; m_we = 1'b0; m_addr = '0; m_wd = '0;
    e_gnt = '0; e_rv = '0; e_rd = '0;
    req = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0;
    new_req(1'b0);
    new_req(1'b1);
    for (int c = 0; c < 300; c++) begin
      if (!m_acc) begin
        e_rv = 2'b00;
        if (req != 2'b00) begin
          // Rotate: the requester after the last winner has priority.
          m_win  = req[~m_last] ? ~m_last : m_last;
          m_last = m_win;
          m_we   = req_we[m_win];
          m_addr = m_win ? req_addr[15:8] : req_addr[7:0];
          m_wd   = m_win ? req_wdata[15:8] : req_wdata[7:0];
          e_gnt  = m_win ? 2'b10 : 2'b01;
          m_acc  = 1'b1;
        end else begin
          e_gnt = 2'b00;
        end
      end else begin
        e_gnt = 2'b00;
        if (m_we) begin
          refmem[m_addr] = m_wd;
          e_rv = 2'b00;
        end else begin
          e_rd = refmem[m_addr];
          e_rv = m_win ? 2'b10 : 2'b01;
        end
        m_acc = 1'b0;
      end
      tick();
      chk("rnd_gnt", 32'(gnt), 32'(e_gnt));
      chk("rnd_rvalid", 32'(rvalid), 32'(e_rv));
      if (e_rv != 2'b00) chk("rnd_rdata", 32'(rdata), 32'(e_rd));
      chk("rnd_wen", 32'(mem_wen), 32'(m_acc && m_we));
      if (m_acc) begin
        chk("rnd_addr", 32'(mem_addr), 32'(m_addr));
        if (m_we) chk("rnd_wdata", 32'(mem_wdata), 32'(m_wd));
      end
      for (int i = 0; i < 2; i++) begin
        logic ib;
        ib = 1'(i);
        if (e_gnt[ib]) begin
          if ($urandom_range(0, 3) != 0) new_req(ib);
          else req[ib] = 1'b0;
        end else if (!req[ib] && ($urandom_range(0, 1) != 0)) begin
          new_req(ib);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
